// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-car hall-call dispatcher.
package elevator_pkg;

  localparam int unsigned NFLOORS = 10;
  localparam int unsigned FLOOR_W = 4;
  localparam int unsigned NCARS   = 3;

  localparam int unsigned CAR_A = 0;
  localparam int unsigned CAR_B = 1;
  localparam int unsigned CAR_C = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } carState_t;

  // Operands are always below NFLOORS, so the difference never wraps.
  function automatic logic [FLOOR_W-1:0] absDiff(input logic [FLOOR_W-1:0] a,
                                                 input logic [FLOOR_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/elevator_dispatcher_if.sv
// Hall-call and per-car objective signals between the bank and the dispatcher.
interface elevator_dispatcher_if;
  import elevator_pkg::*;

  logic [NFLOORS-1:0] hall_req;
  logic [FLOOR_W-1:0] posA;
  logic [FLOOR_W-1:0] posB;
  logic [FLOOR_W-1:0] posC;
  logic [FLOOR_W-1:0] objA;
  logic [FLOOR_W-1:0] objB;
  logic [FLOOR_W-1:0] objC;
  logic [2:0]         door_open;
  logic [2:0]         busy;
  logic [NFLOORS-1:0] pending;

  modport master (
    output hall_req, posA, posB, posC,
    input  objA, objB, objC, door_open, busy, pending
  );

  modport slave (
    input  hall_req, posA, posB, posC,
    output objA, objB, objC, door_open, busy, pending
  );

endinterface

// File: rtl/car_sequencer.sv
// One car: IDLE -> MOVE -> DOOR -> IDLE, with objective register and door timer.
module car_sequencer
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               assignEn,
  input  logic [FLOOR_W-1:0] assignFloor,
  input  logic [FLOOR_W-1:0] pos,
  output carState_t          state,
  output logic [FLOOR_W-1:0] obj,
  output logic               busy,
  output logic               doorOpen
);

  localparam int unsigned TIMER_W = 8;

  logic [TIMER_W-1:0] doorTimer;

  // busy/doorOpen are updated alongside state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      obj       <= '0;
      doorTimer <= '0;
      busy      <= 1'b0;
      doorOpen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (assignEn) begin
            state <= MOVE;
            obj   <= assignFloor;
            busy  <= 1'b1;
          end
        end
        MOVE: begin
          if (pos == obj) begin
            state     <= DOOR;
            doorTimer <= TIMER_W'(DOOR_CYCLES - 1);
            doorOpen  <= 1'b1;
          end
        end
        DOOR: begin
          if (doorTimer == '0) begin
            state    <= IDLE;
            doorOpen <= 1'b0;
            busy     <= 1'b0;
          end else begin
            doorTimer <= doorTimer - TIMER_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          doorOpen <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Latches hall calls and hands the lowest pending floor to the nearest idle car.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 8
) (
  input logic                 clk,
  input logic                 rst,
  elevator_dispatcher_if.slave bus
);

  logic [FLOOR_W-1:0] carPos   [NCARS];
  logic [FLOOR_W-1:0] carObj   [NCARS];
  logic [FLOOR_W-1:0] carDist  [NCARS];
  logic [NFLOORS-1:0] carAbsorb[NCARS];
  carState_t          carState [NCARS];
  logic [NCARS-1:0]   carBusy;
  logic [NCARS-1:0]   carDoor;
  logic [NCARS-1:0]   carIdle;
  logic [NCARS-1:0]   assignEn;

  logic [NFLOORS-1:0] pendingQ;
  logic [NFLOORS-1:0] absorbed;
  logic [NFLOORS-1:0] reqOneHot;
  logic [NFLOORS-1:0] assignedBit;
  logic [FLOOR_W-1:0] reqFloor;
  logic               reqValid;
  logic               selA, selB, selC;

  assign carPos[CAR_A] = bus.posA;
  assign carPos[CAR_B] = bus.posB;
  assign carPos[CAR_C] = bus.posC;

  for (genvar i = 0; i < NCARS; i++) begin : gCar
    car_sequencer #(.DOOR_CYCLES(DOOR_CYCLES)) uCar (
      .clk         (clk),
      .rst         (rst),
      .assignEn    (assignEn[i]),
      .assignFloor (reqFloor),
      .pos         (carPos[i]),
      .state       (carState[i]),
      .obj         (carObj[i]),
      .busy        (carBusy[i]),
      .doorOpen    (carDoor[i])
    );

    // A call at a moving car's target or an open-door floor is already served.
    assign carAbsorb[i] = (carState[i] == MOVE) ? (NFLOORS'(1) << carObj[i]) :
                          (carState[i] == DOOR) ? (NFLOORS'(1) << carPos[i]) :
                                                  '0;
    assign carIdle[i]   = (carState[i] == IDLE);
    assign carDist[i]   = absDiff(carPos[i], reqFloor);
  end

  assign absorbed  = carAbsorb[CAR_A] | carAbsorb[CAR_B] | carAbsorb[CAR_C];
  assign reqValid  = |pendingQ;
  assign reqOneHot = pendingQ & (~pendingQ + NFLOORS'(1));

  // Lowest-index pending floor.
  always_comb begin
    reqFloor = '0;
    for (int f = NFLOORS - 1; f >= 0; f--) begin
      if (pendingQ[f]) reqFloor = FLOOR_W'(f);
    end
  end

  // Nearest idle car; ties go to the lower-lettered car.
  assign selA = carIdle[CAR_A]
              && (!carIdle[CAR_B] || carDist[CAR_A] <= carDist[CAR_B])
              && (!carIdle[CAR_C] || carDist[CAR_A] <= carDist[CAR_C]);
  assign selB = carIdle[CAR_B] && !selA
              && (!carIdle[CAR_C] || carDist[CAR_B] <= carDist[CAR_C]);
  assign selC = carIdle[CAR_C] && !selA && !selB;

  assign assignEn    = {selC, selB, selA} & {NCARS{reqValid}};
  assign assignedBit = (|assignEn) ? reqOneHot : '0;

  always_ff @(posedge clk) begin
    if (rst) pendingQ <= '0;
    else     pendingQ <= (pendingQ | bus.hall_req) & ~absorbed & ~assignedBit;
  end

  assign bus.objA      = carObj[CAR_A];
  assign bus.objB      = carObj[CAR_B];
  assign bus.objC      = carObj[CAR_C];
  assign bus.busy      = carBusy;
  assign bus.door_open = carDoor;
  assign bus.pending   = pendingQ;

endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
- Sequential hall-call scheduler for the three-car elevator bank.
- Latches floor hall calls into a pending set. Assigns each call to the nearest idle car by driving that car's 4-bit objective floor. Tracks each car through move, door-open and idle phases.
- Sits between the hall-call buttons and the per-car objective registers that feed the up/down floor counters. Replaces the ad-hoc, edge-triggered objective capture.

Parameters:
- NFLOORS, 10, number of floors served (floors 0..NFLOORS-1).
- FLOOR_W, 4, floor-number width.
- DOOR_CYCLES, 8, clock cycles a car holds its door open after arrival (range 1..255).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- hall_req  input  NFLOORS  one bit per floor. A bit set in any cycle registers a call.
- posA, posB, posC  input  FLOOR_W  current floor of each car (counter outputs).
- objA, objB, objC  output  FLOOR_W  registered objective floor per car.
- door_open  output  3  bit0=A, bit1=B, bit2=C. High while the car is in DOOR.
- busy  output  3  high while the car is in MOVE or DOOR.
- pending  output  NFLOORS  registered set of unassigned hall calls.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - pending=0;
  - all cars to IDLE;
  - objA/B/C=0;
  - door timers=0;
  - door_open=0 and busy=0.
- Reset mid-operation aborts all moves and discards all calls. Cars stop because obj=0 is driven from the next cycle.
- Per-car FSM states:
  - IDLE: obj holds its last value. Leaves IDLE only on assignment, going to MOVE.
  - MOVE: obj=target. When pos==obj at a clock edge, go to DOOR and load timer=DOOR_CYCLES-1.
  - DOOR: the timer decrements each cycle. When timer==0, go to IDLE. No reassignment while in DOOR.
- Call capture: at each edge, pending_next = (pending | hall_req) & ~absorbed & ~assigned_bit.
  - absorbed[f]=1 when some car is in MOVE with obj==f, or in DOOR with pos==f. Such a call is served by that car and is never set in pending.
  - Any hall_req bit for a floor at or above NFLOORS does not exist (vector width is NFLOORS).
- Dispatch is evaluated combinationally from the registered pending and car states, with at most one assignment per cycle.
  - Floor choice: the lowest-index set bit of pending.
  - Car choice: among IDLE cars, the one with minimum |pos-floor|. Ties resolve to A, then B, then C.
  - If no car is IDLE, nothing happens and the call stays pending.
  - On an assignment edge: the chosen car's obj<=floor, its state becomes MOVE, and pending[floor] is cleared.
- Latency: a hall_req bit sampled at edge k makes pending[f]=1 after edge k. Assignment occurs at edge k+1 if a car is idle, and obj is visible after edge k+1.
- Zero-distance assignment (idle car already at f): the car enters MOVE and then DOOR at the following edge. busy is therefore high for 1+DOOR_CYCLES cycles.
- A hall_req for floor f in the same cycle that f is being assigned is merged into that assignment; it is not re-latched.
- Distance arithmetic uses unsigned FLOOR_W operands and a FLOOR_W-bit absolute-difference result. It never wraps, because pos and floor are both < NFLOORS.
- Outputs:
  - busy[i] = car i in MOVE or DOOR;
  - door_open[i] = car i in DOOR;
  - all outputs are decoded from registered state only.

Decomposition:
- Shared package elevator_pkg:
  - car-state enum (IDLE, MOVE, DOOR);
  - NFLOORS and FLOOR_W constants;
  - car index constants CAR_A/CAR_B/CAR_C.
- Sub-module car_sequencer, instantiated three times. It holds one car's FSM, door timer and obj register, with inputs assign_en and assign_floor.
- The top level holds pending, absorb logic, the lowest-floor priority encoder and the nearest-idle-car selector.

Test Plan:
- Reset then idle: pulse rst, hold all pos=0 -> pending=0, obj=0/0/0, busy=000, door_open=000 for 20 cycles.
- Single call, nearest car:
  - setup: posA=0, posB=5, posC=9 all idle; pulse hall_req[6] at edge k;
  - -> pending[6]=1 after k; at k+1 objB=6, busy=010, pending=0;
  - drive posB 5->6 -> door_open=010 for exactly DOOR_CYCLES cycles, then busy=000.
- Tie break: posA=2, posC=4, B busy; call floor 3 -> objA=3 (A wins tie).
- Absorb: A in MOVE to 7; pulse hall_req[7] -> pending[7] never set; no second car dispatched.
- Saturation:
  - all three cars MOVE; calls 1 and 8 arrive -> pending=0x102 held;
  - A reaches its target and finishes DOOR -> floor 1 assigned to A on the first IDLE cycle; floor 8 waits for the next idle car.
- Reset mid-move: B in MOVE to 9 at pos 4, pending[2]=1; assert rst -> objB=0, pending=0, busy=000 at next edge.
